// File: rtl/dma_addrgen_mc.sv
// Multi-channel DMA address generator / word counter (Am2942 style), one channel addressed per cycle.
// Optional ring-buffer auto-reinitialise on done is enabled by defining DMA_ADDRGEN_AUTOINIT_EN.
module dma_addrgen_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                cp,
    input  logic                clr,
    input  logic [2:0]          i,
    input  logic                ien_,
    input  logic [CHW-1:0]      ch,
    inout  wire  [WIDTH-1:0]    d,
    input  logic                oed_,
    input  logic                aci_,
    input  logic                wci_,
    output logic                aco_,
    output logic                wco_,
    output logic                done,
    output logic [CHANNELS-1:0] done_vec
);

    logic [WIDTH-1:0] ar  [0:CHANNELS-1];
    logic [WIDTH-1:0] ac  [0:CHANNELS-1];
    logic [WIDTH-1:0] wcr [0:CHANNELS-1];
    logic [WIDTH-1:0] wc  [0:CHANNELS-1];
    logic [2:0]       cr  [0:CHANNELS-1];

    logic             ch_ok;
    logic [WIDTH-1:0] sel_ar, sel_ac, sel_wcr, sel_wc;
    logic [2:0]       sel_cr;
    logic [1:0]       mode;
    logic             dir;
    logic [WIDTH-1:0] ac_step, wc_step, wc_init, wc_load, d_out;
    logic             autoinit;

    // Channel numbers beyond CHANNELS (non power-of-two counts) select nothing.
    assign ch_ok = (32'(ch) < CHANNELS);

    always_comb begin
        sel_ar  = '0;
        sel_ac  = '0;
        sel_wcr = '0;
        sel_wc  = '0;
        sel_cr  = '0;
        if (ch_ok) begin
            sel_ar  = ar[ch];
            sel_ac  = ac[ch];
            sel_wcr = wcr[ch];
            sel_wc  = wc[ch];
            sel_cr  = cr[ch];
        end
    end

    assign mode = sel_cr[1:0];
    assign dir  = sel_cr[2];

    always_comb begin
        ac_step = dir ? (sel_ac - WIDTH'(1)) : (sel_ac + WIDTH'(1));
        case (mode)
            2'd0:    wc_step = sel_wc - WIDTH'(1);
            2'd2:    wc_step = sel_wc;
            default: wc_step = sel_wc + WIDTH'(1);
        endcase
        // Mode 1 counts words up from zero towards WCR.
        wc_init = (mode == 2'd1) ? '0 : sel_wcr;
        wc_load = (mode == 2'd1) ? '0 : d;
    end

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            case (cr[n][1:0])
                2'd0:    done_vec[n] = (wc[n] == WIDTH'(1));
                2'd1:    done_vec[n] = ((wc[n] + WIDTH'(1)) == wcr[n]);
                2'd2:    done_vec[n] = (ac[n] == wcr[n]);
                default: done_vec[n] = 1'b0;
            endcase
        end
    end

    assign done = ch_ok ? done_vec[ch] : 1'b0;

`ifdef DMA_ADDRGEN_AUTOINIT_EN
    assign autoinit = done;
`else
    assign autoinit = 1'b0;
`endif

    assign aco_ = !(!aci_ && (dir ? (sel_ac == '0) : (sel_ac == '1)));
    assign wco_ = !(!wci_ && (((mode == 2'd0) && (sel_wc == '0)) ||
                              ((mode == 2'd3) && (sel_wc == '1))));

    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            for (int n = 0; n < CHANNELS; n++) begin
                ar[n]  <= '0;
                ac[n]  <= '0;
                wcr[n] <= '0;
                wc[n]  <= '0;
                cr[n]  <= '0;
            end
        end else if (!ien_ && ch_ok) begin
            case (i)
                3'b000: cr[ch] <= d[2:0];
                3'b100: begin
                    ac[ch] <= sel_ar;
                    wc[ch] <= wc_init;
                end
                3'b101: begin
                    ar[ch] <= d;
                    ac[ch] <= d;
                end
                3'b110: begin
                    wcr[ch] <= d;
                    wc[ch]  <= wc_load;
                end
                3'b111: begin
                    if (autoinit) begin
                        ac[ch] <= sel_ar;
                        wc[ch] <= wc_init;
                    end else begin
                        if (!aci_) ac[ch] <= ac_step;
                        if (!wci_) wc[ch] <= wc_step;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read instructions pick CR or WC; every other code presents AC on the bus.
    always_comb begin
        case (i)
            3'b001:  d_out = {{(WIDTH-3){1'b1}}, sel_cr};
            3'b010:  d_out = sel_wc;
            default: d_out = sel_ac;
        endcase
    end

    assign d = oed_ ? {WIDTH{1'bz}} : d_out;

endmodule

// File: tb/tb_dma_addrgen_mc.sv
// Directed scoreboard bench for dma_addrgen_mc (WIDTH=8, CHANNELS=4).
module tb_dma_addrgen_mc;

    localparam int W   = 8;
    localparam int CHN = 4;
    localparam int CHW = 2;

    logic           cp = 1'b0;
    logic           clr;
    logic [2:0]     i;
    logic           ien_;
    logic [CHW-1:0] ch;
    wire  [W-1:0]   d;
    logic           oed_;
    logic           aci_;
    logic           wci_;
    logic           aco_;
    logic           wco_;
    logic           done;
    logic [CHN-1:0] done_vec;

    logic [W-1:0]   drv;
    logic           drv_en;

    logic [W-1:0]   exp_q[$];
    int             pass_cnt  = 0;
    int             total_cnt = 0;

    assign d = drv_en ? drv : {W{1'bz}};

    dma_addrgen_mc #(.WIDTH(W), .CHANNELS(CHN)) dut (
        .cp(cp), .clr(clr), .i(i), .ien_(ien_), .ch(ch), .d(d), .oed_(oed_),
        .aci_(aci_), .wci_(wci_), .aco_(aco_), .wco_(wco_), .done(done),
        .done_vec(done_vec)
    );

    // clock / reset
    always #5 cp = ~cp;

    // scoreboard
    task automatic push_exp(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h with empty expected queue", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) pass_cnt++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // drivers
    task automatic op(input logic [CHW-1:0] c, input logic [2:0] instr, input logic [W-1:0] data);
        @(negedge cp);
        ch     = c;
        i      = instr;
        oed_   = 1'b1;
        drv    = data;
        drv_en = (instr == 3'b000) || (instr == 3'b101) || (instr == 3'b110);
        ien_   = 1'b0;
        @(posedge cp);
        #1;
        ien_   = 1'b1;
        drv_en = 1'b0;
    endtask

    task automatic cnt(input logic [CHW-1:0] c, input logic a, input logic w);
        @(negedge cp);
        ch   = c;
        i    = 3'b111;
        aci_ = a;
        wci_ = w;
        ien_ = 1'b0;
        @(posedge cp);
        #1;
        ien_ = 1'b1;
    endtask

    task automatic setup(input logic [CHW-1:0] c, input logic [2:0] crv,
                         input logic [W-1:0] arv, input logic [W-1:0] wcrv);
        op(c, 3'b000, {5'b0, crv});
        op(c, 3'b101, arv);
        op(c, 3'b110, wcrv);
    endtask

    task automatic rd(input string tag, input logic [CHW-1:0] c, input logic [2:0] instr,
                      input logic [W-1:0] e);
        push_exp(e);
        ien_ = 1'b1;
        ch   = c;
        i    = instr;
        oed_ = 1'b0;
        #1;
        check(tag, d);
        oed_ = 1'b1;
    endtask

    // expected status packed as {aco_, wco_, done}
    task automatic st(input string tag, input logic [CHW-1:0] c, input logic a, input logic w,
                      input logic [2:0] e);
        push_exp({5'b0, e});
        ien_ = 1'b1;
        ch   = c;
        aci_ = a;
        wci_ = w;
        #1;
        check(tag, {5'b0, aco_, wco_, done});
    endtask

    task automatic vec(input string tag, input logic [CHN-1:0] e);
        push_exp({4'b0, e});
        #1;
        check(tag, {4'b0, done_vec});
    endtask

    initial begin
        clr = 1'b1; ien_ = 1'b1; oed_ = 1'b1; aci_ = 1'b1; wci_ = 1'b1;
        i = 3'b000; ch = '0; drv = '0; drv_en = 1'b0;
        repeat (2) @(posedge cp);
        @(negedge cp);
        clr = 1'b0;

        // reset state
        for (int c = 0; c < CHN; c++) rd("rst_ac", CHW'(c), 3'b011, 8'h00);
        rd("rst_cr", 0, 3'b001, 8'hF8);
        vec("rst_vec", 4'b0000);
        st("rst_st", 0, 1'b1, 1'b1, 3'b110);

        // mode 0, increment, channel 0
        setup(0, 3'b000, 8'h08, 8'h03);
        rd("m0_ac0", 0, 3'b011, 8'h08);
        rd("m0_wc0", 0, 3'b010, 8'h03);
        cnt(0, 1'b0, 1'b0);
        rd("m0_ac1", 0, 3'b011, 8'h09);
        st("m0_st1", 0, 1'b0, 1'b0, 3'b110);
        cnt(0, 1'b0, 1'b0);
        rd("m0_ac2", 0, 3'b011, 8'h0A);
        st("m0_st2", 0, 1'b0, 1'b0, 3'b111);
        cnt(0, 1'b0, 1'b0);
`ifdef DMA_ADDRGEN_AUTOINIT_EN
        rd("m0_ac3", 0, 3'b011, 8'h08);
        st("m0_st3", 0, 1'b0, 1'b0, 3'b110);
`else
        rd("m0_ac3", 0, 3'b011, 8'h0B);
        st("m0_st3", 0, 1'b0, 1'b0, 3'b100);
`endif
        cnt(0, 1'b0, 1'b0);
`ifdef DMA_ADDRGEN_AUTOINIT_EN
        rd("m0_ac4", 0, 3'b011, 8'h09);
        rd("m0_wc4", 0, 3'b010, 8'h02);
`else
        rd("m0_ac4", 0, 3'b011, 8'h0C);
        rd("m0_wc4", 0, 3'b010, 8'hFF);
`endif

        // channel isolation and address carry
        setup(1, 3'b000, 8'hFE, 8'h10);
        repeat (3) cnt(0, 1'b0, 1'b0);
        rd("iso_ac", 1, 3'b011, 8'hFE);
        cnt(1, 1'b0, 1'b0);
        rd("iso_ff", 1, 3'b011, 8'hFF);
        st("iso_aco0", 1, 1'b0, 1'b0, 3'b010);
        cnt(1, 1'b0, 1'b0);
        rd("iso_00", 1, 3'b011, 8'h00);
        st("iso_aco1", 1, 1'b0, 1'b0, 3'b110);
        rd("iso_wc", 1, 3'b010, 8'h0E);

        // mode 2, decrement, channel 2
        setup(2, 3'b110, 8'h08, 8'h05);
        cnt(2, 1'b0, 1'b0);
        rd("m2_ac1", 2, 3'b011, 8'h07);
        st("m2_st1", 2, 1'b0, 1'b0, 3'b110);
        cnt(2, 1'b0, 1'b0);
        rd("m2_ac2", 2, 3'b011, 8'h06);
        cnt(2, 1'b0, 1'b0);
        rd("m2_ac3", 2, 3'b011, 8'h05);
        rd("m2_wc", 2, 3'b010, 8'h05);
        st("m2_st3", 2, 1'b0, 1'b0, 3'b111);
        vec("m2_vec", 4'b0100);

        // mode 3, word count up with carry, channel 3
        setup(3, 3'b011, 8'h00, 8'hFC);
        rd("m3_wc0", 3, 3'b010, 8'hFC);
        cnt(3, 1'b1, 1'b0);
        rd("m3_wc1", 3, 3'b010, 8'hFD);
        st("m3_st1", 3, 1'b1, 1'b0, 3'b110);
        cnt(3, 1'b1, 1'b0);
        rd("m3_wc2", 3, 3'b010, 8'hFE);
        cnt(3, 1'b1, 1'b0);
        rd("m3_wc3", 3, 3'b010, 8'hFF);
        st("m3_wco", 3, 1'b1, 1'b0, 3'b100);
        cnt(3, 1'b1, 1'b0);
        rd("m3_wrap", 3, 3'b010, 8'h00);
        st("m3_st4", 3, 1'b1, 1'b0, 3'b110);
        rd("m3_ac", 3, 3'b011, 8'h00);

        // count past done
        setup(0, 3'b000, 8'h08, 8'h02);
        cnt(0, 1'b0, 1'b0);
        st("ai_done", 0, 1'b1, 1'b1, 3'b111);
        cnt(0, 1'b0, 1'b0);
`ifdef DMA_ADDRGEN_AUTOINIT_EN
        rd("ai_ac", 0, 3'b011, 8'h08);
        rd("ai_wc", 0, 3'b010, 8'h02);
`else
        rd("ai_ac", 0, 3'b011, 8'h0A);
        rd("ai_wc", 0, 3'b010, 8'h00);
`endif

        // mode 1, word count up from zero, plus reinitialise
        setup(1, 3'b001, 8'h20, 8'h03);
        rd("m1_wc0", 1, 3'b010, 8'h00);
        cnt(1, 1'b0, 1'b0);
        cnt(1, 1'b0, 1'b0);
        rd("m1_wc2", 1, 3'b010, 8'h02);
        st("m1_done", 1, 1'b1, 1'b1, 3'b111);
        op(1, 3'b100, 8'h00);
        rd("m1_ri_ac", 1, 3'b011, 8'h20);
        rd("m1_ri_wc", 1, 3'b010, 8'h00);

        // disabled instruction leaves state alone
        @(negedge cp);
        ch = 1; i = 3'b101; oed_ = 1'b1; drv = 8'h55; drv_en = 1'b1; ien_ = 1'b1;
        @(posedge cp);
        #1;
        drv_en = 1'b0;
        rd("ien_hold", 1, 3'b011, 8'h20);

        // asynchronous clear during a pending count
        setup(2, 3'b000, 8'h40, 8'h30);
        cnt(2, 1'b0, 1'b0);
        rd("clr_pre", 2, 3'b011, 8'h41);
        @(negedge cp);
        ch = 2; i = 3'b111; aci_ = 1'b0; wci_ = 1'b0; ien_ = 1'b0;
        #1 clr = 1'b1;
        #1 ien_ = 1'b1;
        rd("clr_async", 2, 3'b011, 8'h00);
        @(negedge cp);
        clr = 1'b0;
        rd("clr_wc", 2, 3'b010, 8'h00);
        rd("clr_cr", 2, 3'b001, 8'hF8);
        rd("clr_ac0", 0, 3'b011, 8'h00);
        vec("clr_vec", 4'b0000);
        st("clr_st", 2, 1'b1, 1'b1, 3'b110);
        cnt(2, 1'b0, 1'b0);
        rd("post_ac", 2, 3'b011, 8'h01);
        rd("post_wc", 2, 3'b010, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
